// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests, branch resolution and trap
// handshake between the core datapath/CSR unit and pipe_ctrl.
interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic [31:0] id_pc_i;
    logic        id_valid_i;
    logic        trap_req_i;
    logic [31:0] trap_vec_i;
    logic [4:0]  stalled_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        trap_ack_o;
    logic [31:0] trap_epc_o;
    logic        hang_o;

    // Core side: produces requests, consumes control.
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output branch_flag_i, branch_addr_i, id_pc_i, id_valid_i,
        output trap_req_i, trap_vec_i,
        input  stalled_o, flush_o, redirect_o, redirect_pc_o,
        input  trap_ack_o, trap_epc_o, hang_o
    );

    // Controller side.
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  branch_flag_i, branch_addr_i, id_pc_i, id_valid_i,
        input  trap_req_i, trap_vec_i,
        output stalled_o, flush_o, redirect_o, redirect_pc_o,
        output trap_ack_o, trap_epc_o, hang_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall merge, branch flush/redirect, precise trap
// entry sequencing (IDLE -> DRAIN -> FIRE) and a sticky stall watchdog.
module pipe_ctrl #(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FIRE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               hang_reg;
    logic [31:0]        epc_reg;

    logic [3:0]         req;
    logic [4:0]         merge;
    logic [4:0]         stalled_next;
    logic               flush_next;
    logic               redirect_next;
    logic [31:0]        redirect_pc_next;
    logic               trap_ack_next;
    logic               drain_done;

    // Requesters ordered upstream to downstream: {mem, ex, id, if}.
    assign req = {bus.stallreq_mem_i, bus.stallreq_ex_i,
                  bus.stallreq_id_i, bus.stallreq_if_i};

    // Stage gi stops if any requester at or below it in the pipe asks;
    // the pc always stops together with the if stage.
    generate
        for (genvar gi = 1; gi < 5; gi++) begin : g_merge
            assign merge[gi] = |(req >> (gi - 1));
        end
    endgenerate
    assign merge[0] = merge[1];

    // EX/MEM idle, no redirect competing, and a real instruction to tag.
    assign drain_done = !bus.stallreq_ex_i && !bus.stallreq_mem_i &&
                        !bus.branch_flag_i && bus.id_valid_i;

    // Next state and combinational pipeline controls.
    always_comb begin
        state_next       = state_reg;
        stalled_next     = merge;
        flush_next       = 1'b0;
        redirect_next    = 1'b0;
        redirect_pc_next = 32'd0;
        trap_ack_next    = 1'b0;
        if (bus.branch_flag_i) begin
            flush_next       = 1'b1;
            redirect_next    = 1'b1;
            redirect_pc_next = bus.branch_addr_i;
        end
        case (state_reg)
            S_IDLE: begin
                if (bus.trap_req_i) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                stalled_next = merge | 5'b00111;
                if (!bus.trap_req_i)   state_next = S_IDLE;
                else if (drain_done)   state_next = S_FIRE;
            end
            S_FIRE: begin
                // Trap redirect must land regardless of any stall request.
                stalled_next     = 5'b00000;
                flush_next       = 1'b1;
                redirect_next    = 1'b1;
                redirect_pc_next = bus.trap_vec_i;
                trap_ack_next    = 1'b1;
                state_next       = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Trap FSM state and captured interrupted PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            epc_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DRAIN && state_next == S_FIRE)
                epc_reg <= bus.id_pc_i;
        end
    end

    // Consecutive-stall counter, saturating at all-ones.
    always_comb begin
        cnt_next = '0;
        if (stalled_next[0])
            cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    end

    // Watchdog counter and sticky hang flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            hang_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (cnt_next == TIMEOUT_C) hang_reg <= 1'b1;
        end
    end

    assign bus.stalled_o     = stalled_next;
    assign bus.flush_o       = flush_next;
    assign bus.redirect_o    = redirect_next;
    assign bus.redirect_pc_o = redirect_pc_next;
    assign bus.trap_ack_o    = trap_ack_next;
    assign bus.trap_epc_o    = epc_reg;
    assign bus.hang_o        = hang_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: stall-merge vector table, hand-written trap and
// watchdog sequences, then randomized traffic against a reference model.
module tb_pipe_ctrl;

    localparam int TMO = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.STALL_TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;     // {mem, ex, id, if}
        logic        br;
        logic [31:0] ba;
        logic [4:0]  e_st;
        logic        e_fl;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [10];

    // Reference model state
    bit          m_drain;
    bit          m_fire;
    logic [31:0] m_epc;
    int          m_run;
    bit          m_hang;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq_if_i  = 1'b0;
        bus.stallreq_id_i  = 1'b0;
        bus.stallreq_ex_i  = 1'b0;
        bus.stallreq_mem_i = 1'b0;
        bus.branch_flag_i  = 1'b0;
        bus.branch_addr_i  = 32'd0;
        bus.id_pc_i        = 32'd0;
        bus.id_valid_i     = 1'b0;
        bus.trap_req_i     = 1'b0;
        bus.trap_vec_i     = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_drain = 0; m_fire = 0; m_epc = 32'd0; m_run = 0; m_hang = 0;
    endtask

    // Number of stopped stages from the deepest requester.
    function automatic logic [4:0] model_stall(input logic [3:0] r);
        int n;
        n = r[3] ? 5 : r[2] ? 4 : r[1] ? 3 : r[0] ? 2 : 0;
        return 5'((32'd1 << n) - 1);
    endfunction

    // Compare all outputs against the model, then advance the model one edge.
    task automatic model_cycle(input int idx);
        logic [3:0]  r;
        logic [4:0]  e_st;
        logic        e_fl;
        logic [31:0] e_pc;
        r = {bus.stallreq_mem_i, bus.stallreq_ex_i, bus.stallreq_id_i, bus.stallreq_if_i};
        if (m_fire) begin
            e_st = 5'b0; e_fl = 1'b1; e_pc = bus.trap_vec_i;
        end else begin
            e_st = model_stall(r) | (m_drain ? 5'b00111 : 5'b0);
            e_fl = bus.branch_flag_i;
            e_pc = bus.branch_flag_i ? bus.branch_addr_i : 32'd0;
        end
        chk("rnd_stalled",  32'(bus.stalled_o),  32'(e_st));
        chk("rnd_flush",    32'(bus.flush_o),    32'(e_fl));
        chk("rnd_redirect", 32'(bus.redirect_o), 32'(e_fl));
        chk("rnd_rpc",      bus.redirect_pc_o,   e_pc);
        chk("rnd_ack",      32'(bus.trap_ack_o), 32'(m_fire));
        chk("rnd_epc",      bus.trap_epc_o,      m_epc);
        chk("rnd_hang",     32'(bus.hang_o),     32'(m_hang));
        $display("rnd %0d req=%b br=%b tr=%b st=%b ack=%b hang=%b",
                 idx, r, bus.branch_flag_i, bus.trap_req_i, bus.stalled_o,
                 bus.trap_ack_o, bus.hang_o);
        if (m_fire) begin
            m_fire = 0;
        end else if (!m_drain) begin
            m_drain = bus.trap_req_i;
        end else if (!bus.trap_req_i) begin
            m_drain = 0;
        end else if (!bus.stallreq_ex_i && !bus.stallreq_mem_i &&
                     !bus.branch_flag_i && bus.id_valid_i) begin
            m_drain = 0; m_fire = 1; m_epc = bus.id_pc_i;
        end
        m_run = e_st[0] ? m_run + 1 : 0;
        if (m_run >= TMO) m_hang = 1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        // Reset state
        chk("rst_stalled",  32'(bus.stalled_o),  32'd0);
        chk("rst_flush",    32'(bus.flush_o),    32'd0);
        chk("rst_redirect", 32'(bus.redirect_o), 32'd0);
        chk("rst_rpc",      bus.redirect_pc_o,   32'd0);
        chk("rst_ack",      32'(bus.trap_ack_o), 32'd0);
        chk("rst_epc",      bus.trap_epc_o,      32'd0);
        chk("rst_hang",     32'(bus.hang_o),     32'd0);
        $display("reset checked");
        tick();
        rst_n = 1'b1;
        tick();

        // Stall merge / branch table, applied in IDLE
        vt[0] = '{4'b1010, 1'b0, 32'h0,        5'b11111, 1'b0, 32'h0};
        vt[1] = '{4'b0010, 1'b0, 32'h0,        5'b00111, 1'b0, 32'h0};
        vt[2] = '{4'b0000, 1'b0, 32'h0,        5'b00000, 1'b0, 32'h0};
        vt[3] = '{4'b0001, 1'b0, 32'h0,        5'b00011, 1'b0, 32'h0};
        vt[4] = '{4'b0100, 1'b0, 32'h0,        5'b01111, 1'b0, 32'h0};
        vt[5] = '{4'b1000, 1'b0, 32'h0,        5'b11111, 1'b0, 32'h0};
        vt[6] = '{4'b0011, 1'b0, 32'h0,        5'b00111, 1'b0, 32'h0};
        vt[7] = '{4'b0101, 1'b0, 32'h0,        5'b01111, 1'b0, 32'h0};
        vt[8] = '{4'b0000, 1'b1, 32'h80000040, 5'b00000, 1'b1, 32'h80000040};
        vt[9] = '{4'b0110, 1'b1, 32'h12345678, 5'b01111, 1'b1, 32'h12345678};
        for (int i = 0; i < 10; i++) begin
            {bus.stallreq_mem_i, bus.stallreq_ex_i, bus.stallreq_id_i, bus.stallreq_if_i} = vt[i].req;
            bus.branch_flag_i = vt[i].br;
            bus.branch_addr_i = vt[i].ba;
            #2;
            chk("vec_stalled",  32'(bus.stalled_o),  32'(vt[i].e_st));
            chk("vec_flush",    32'(bus.flush_o),    32'(vt[i].e_fl));
            chk("vec_redirect", 32'(bus.redirect_o), 32'(vt[i].e_fl));
            chk("vec_rpc",      bus.redirect_pc_o,   vt[i].e_pc);
            $display("vec %0d req=%b br=%b st=%b fl=%b", i, vt[i].req, vt[i].br,
                     bus.stalled_o, bus.flush_o);
        end
        idle_inputs();
        do_reset();

        // Clean trap: DRAIN one cycle, then FIRE
        bus.id_valid_i = 1'b1; bus.id_pc_i = 32'h80000100;
        bus.trap_vec_i = 32'h80000200; bus.trap_req_i = 1'b1;
        #2;
        chk("clean_idle_st", 32'(bus.stalled_o), 32'd0);
        tick();
        chk("clean_drain_st",  32'(bus.stalled_o),  32'b00111);
        chk("clean_drain_ack", 32'(bus.trap_ack_o), 32'd0);
        tick();
        bus.trap_req_i = 1'b0;
        #1;
        chk("clean_fire_ack", 32'(bus.trap_ack_o), 32'd1);
        chk("clean_fire_rd",  32'(bus.redirect_o), 32'd1);
        chk("clean_fire_fl",  32'(bus.flush_o),    32'd1);
        chk("clean_fire_rpc", bus.redirect_pc_o,   32'h80000200);
        chk("clean_fire_st",  32'(bus.stalled_o),  32'd0);
        chk("clean_fire_epc", bus.trap_epc_o,      32'h80000100);
        tick();
        chk("clean_after_ack", 32'(bus.trap_ack_o), 32'd0);
        chk("clean_epc_hold",  bus.trap_epc_o,      32'h80000100);
        $display("seq clean trap done");

        // Trap with EX stall for 3 drain cycles: ack on cycle 5
        bus.id_pc_i = 32'h80000180; bus.trap_req_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.stallreq_ex_i = (c >= 1 && c <= 3);
            #1;
            if (c >= 1 && c <= 3) chk("drain_ex_st", 32'(bus.stalled_o), 32'b01111);
            chk("drain_ack", 32'(bus.trap_ack_o), (c == 5) ? 32'd1 : 32'd0);
            tick();
        end
        chk("drain_epc", bus.trap_epc_o, 32'h80000180);
        $display("seq drain trap done");

        // Branch in DRAIN: branch first, then ack with new PC
        bus.stallreq_ex_i = 1'b0;
        bus.id_pc_i = 32'h80000300;
        tick();  // IDLE with trap_req held -> DRAIN
        bus.branch_flag_i = 1'b1; bus.branch_addr_i = 32'h80000040;
        #1;
        chk("br_drain_rd",  32'(bus.redirect_o), 32'd1);
        chk("br_drain_rpc", bus.redirect_pc_o,   32'h80000040);
        chk("br_drain_st",  32'(bus.stalled_o),  32'b00111);
        chk("br_drain_ack", 32'(bus.trap_ack_o), 32'd0);
        tick();
        bus.branch_flag_i = 1'b0; bus.id_pc_i = 32'h80000044;
        #1;
        chk("br_wait_ack", 32'(bus.trap_ack_o), 32'd0);
        tick();
        bus.trap_req_i = 1'b0;
        #1;
        chk("br_fire_ack", 32'(bus.trap_ack_o), 32'd1);
        chk("br_fire_rpc", bus.redirect_pc_o,   32'h80000200);
        chk("br_fire_epc", bus.trap_epc_o,      32'h80000044);
        tick();
        $display("seq branch in drain done");

        // Trap withdrawn in DRAIN
        bus.trap_req_i = 1'b1;
        tick();
        bus.trap_req_i = 1'b0;
        #1;
        chk("wd_drain_st", 32'(bus.stalled_o), 32'b00111);
        tick();
        chk("wd_idle_st",  32'(bus.stalled_o),  32'd0);
        chk("wd_idle_ack", 32'(bus.trap_ack_o), 32'd0);
        tick();
        chk("wd_no_ack", 32'(bus.trap_ack_o), 32'd0);
        $display("seq trap withdrawn done");

        // Reset mid-DRAIN aborts with no ack
        bus.trap_req_i = 1'b1;
        tick();
        rst_n = 1'b0;
        bus.trap_req_i = 1'b0;
        #1;
        chk("rstd_st", 32'(bus.stalled_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstd_ack", 32'(bus.trap_ack_o), 32'd0);
        $display("seq reset mid-drain done");

        // Watchdog: 7 stalled cycles no hang, 8 -> hang, sticky, reset clears
        idle_inputs();
        do_reset();
        bus.stallreq_if_i = 1'b1;
        repeat (7) tick();
        bus.stallreq_if_i = 1'b0;
        chk("wdog_7", 32'(bus.hang_o), 32'd0);
        tick();
        chk("wdog_7_after", 32'(bus.hang_o), 32'd0);
        bus.stallreq_if_i = 1'b1;
        repeat (7) tick();
        chk("wdog_pre8", 32'(bus.hang_o), 32'd0);
        tick();
        chk("wdog_8", 32'(bus.hang_o), 32'd1);
        bus.stallreq_if_i = 1'b0;
        repeat (3) tick();
        chk("wdog_sticky", 32'(bus.hang_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wdog_rst", 32'(bus.hang_o), 32'd0);
        tick();
        rst_n = 1'b1;
        $display("seq watchdog done");

        // Randomized traffic against the reference model
        idle_inputs();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_hang", 32'(bus.hang_o),     32'd0);
                chk("rnd_rst_ack",  32'(bus.trap_ack_o), 32'd0);
                tick();
                rst_n = 1'b1;
                m_drain = 0; m_fire = 0; m_epc = 32'd0; m_run = 0; m_hang = 0;
            end
            bus.stallreq_if_i  = ($urandom_range(0, 7) == 0);
            bus.stallreq_id_i  = ($urandom_range(0, 7) == 0);
            bus.stallreq_ex_i  = ($urandom_range(0, 5) == 0);
            bus.stallreq_mem_i = ($urandom_range(0, 9) == 0);
            bus.branch_flag_i  = ($urandom_range(0, 5) == 0);
            bus.branch_addr_i  = $urandom;
            bus.id_pc_i        = $urandom;
            bus.id_valid_i     = ($urandom_range(0, 3) != 0);
            bus.trap_vec_i     = $urandom;
            if ($urandom_range(0, 6) == 0) bus.trap_req_i = ~bus.trap_req_i;
            #1;
            model_cycle(i);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
